operand_select_pipe: RTL and testbench
======================================

// Module: operand_select_pipe
// PURPOSE
//  - Parametrised N-way operand selector feeding the ALU operand port of the multicycle core.
//  - Selected source is registered behind a valid/ready handshake with a 2-entry skid buffer.
//  - Full throughput (1 op/cycle) while stalled consumers never lose or corrupt data.
//  - Generalises the fixed 3-input 32-bit ALUSrc selector in width, source count and flow control.
// PARAMETERS
//  WIDTH        32      operand width in bits
//  NUM_SRC      3       number of selectable sources; legal range 2..2**SEL_W
//  SEL_W        2       select field width
//  DEFAULT_VAL  32'h0   value captured when sel >= NUM_SRC (WIDTH bits)
// PORTS
//  clk        in   1                clock, all state updates on rising edge
//  reset      in   1                synchronous, active-high reset
//  src        in   NUM_SRC*WIDTH    flattened sources; source k = src[k*WIDTH +: WIDTH]
//  sel        in   SEL_W            source index, sampled with in_valid
//  in_valid   in   1                producer has an operand request this cycle
//  in_ready   out  1                block can accept; registered (no comb path from out_ready)
//  out_data   out  WIDTH            selected operand
//  out_valid  out  1                out_data is valid
//  out_ready  in   1                consumer takes out_data this cycle
//  err_clr    in   1                clears sel_err (only with OPMUX_SELERR_EN)
//  sel_err    out  1                sticky out-of-range flag (only with OPMUX_SELERR_EN)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (reset). No async paths.
//  - Reset: out_valid=0, out_data=0, in_ready=1, skid empty, sel_err=0. Reset wins over all inputs.
//  - Accept = in_valid & in_ready; Pop = out_valid & out_ready.
//  - Mux evaluated combinationally in the accept cycle: src slice[sel], or DEFAULT_VAL if sel >= NUM_SRC.
//  - src/sel ignored in cycles without Accept; later src changes never affect captured data.
//  - Latency: accept in cycle t -> out_valid=1 with the data in cycle t+1 (empty pipe).
//  - States: EMPTY (out_valid=0), ONE (main reg valid), FULL (main + skid valid).
//    EMPTY: Accept -> ONE (main<=mux); else stay.
//    ONE:   Accept&Pop -> ONE (main<=mux); Accept&!Pop -> FULL (skid<=mux);
//           !Accept&Pop -> EMPTY; else hold.
//    FULL:  Pop -> ONE (main<=skid); else hold. in_ready=0 in FULL, so no Accept.
//  - in_ready = (next state != FULL), registered.
//  - Order preserved: FIFO semantics, skid never overtakes main.
//  - Stability: while out_valid & !out_ready, out_data is held constant.
//  - out_data not cleared on Pop; only out_valid qualifies it.
//  - Reset mid-operation drops both entries; no partial output afterwards.
// CONFIGURATION
//  - Macro OPMUX_SELERR_EN.
//  - Defined: sel_err/err_clr ports exist.
//    sel_err set on the cycle after any Accept with sel >= NUM_SRC.
//    err_clr clears sel_err next cycle; simultaneous set and clear -> set wins.
//    Data path unchanged: DEFAULT_VAL is still captured.
//  - Undefined: sel_err/err_clr ports absent; out-of-range selects silently yield DEFAULT_VAL.
// TESTING (defaults WIDTH=32, NUM_SRC=3, SEL_W=2)
//  - Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0 after release.
//  - Select: src={32'hC,32'hB,32'hA}, sel=0,1,2 on consecutive cycles, out_ready=1
//      -> out_data A,B,C on cycles t+1..t+3, out_valid=1 each cycle.
//  - Out-of-range: sel=3 -> out_data=32'h0; with OPMUX_SELERR_EN sel_err=1 until err_clr.
//  - Stall/skid: out_ready=0, send 32'h11 then 32'h22
//      -> in_ready=0 after 2nd accept, out_data holds 32'h11.
//      Raise out_ready -> 32'h11 then 32'h22 in order; in_ready=1 again after first pop.
//  - Reset while FULL: assert reset -> out_valid=0 next cycle; old 32'h22 never appears.
//  - Random valid/ready soak, 10k cycles vs scoreboard queue: no loss, dup or reorder.

Source files
------------

// File: rtl/operand_select_pipe_if.sv
// Valid/ready operand-request bus between a producer (master) and operand_select_pipe (slave).
interface operand_select_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2
);
    logic [NUM_SRC*WIDTH-1:0] src;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output src, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  src, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/operand_select_pipe.sv
// N-way operand selector registered behind a valid/ready handshake with a 2-entry skid buffer.
// Optional sticky out-of-range flag (sel_err/err_clr) enabled by defining OPMUX_SELERR_EN.
module operand_select_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_SRC     = 3,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
`ifdef OPMUX_SELERR_EN
    input  logic                err_clr,
    output logic                sel_err,
`endif
    operand_select_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] mux_val;
    logic             accept;
    logic             pop;

    // Out-of-range selects fall through to DEFAULT_VAL.
    always_comb begin
        mux_val = DEFAULT_VAL;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(bus.sel) == k) begin
                mux_val = bus.src[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= mux_val;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_q <= mux_val;
                    end else if (accept) begin
                        skid_q     <= mux_val;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the pipe.
                    if (pop) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    assign bus.out_data  = main_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

`ifdef OPMUX_SELERR_EN
    logic sel_oob;
    logic sel_err_q;

    assign sel_oob = int'(bus.sel) >= NUM_SRC;

    // A new out-of-range accept outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (accept && sel_oob) begin
            sel_err_q <= 1'b1;
        end else if (err_clr) begin
            sel_err_q <= 1'b0;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_operand_select_pipe.sv
// Self-checking bench for operand_select_pipe: directed scenarios plus a random valid/ready soak
// checked against a queue-based reference model.
module tb_operand_select_pipe;

    localparam int               WIDTH       = 32;
    localparam int               NUM_SRC     = 3;
    localparam int               SEL_W       = 2;
    localparam logic [WIDTH-1:0] DEFAULT_VAL = 32'h0;

    logic clk;
    logic reset;
`ifdef OPMUX_SELERR_EN
    logic err_clr;
    logic sel_err;
    logic err_exp;
`endif

    operand_select_pipe_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    operand_select_pipe #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEFAULT_VAL(DEFAULT_VAL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef OPMUX_SELERR_EN
        .err_clr(err_clr),
        .sel_err(sel_err),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [WIDTH-1:0] q[$];
    logic             did_pop;
    logic [WIDTH-1:0] pop_act;
    logic [WIDTH-1:0] pop_exp;

    function automatic logic [WIDTH-1:0] ref_sel(input logic [NUM_SRC*WIDTH-1:0] s,
                                                 input logic [SEL_W-1:0] k);
        if (int'(k) < NUM_SRC) return s[int'(k)*WIDTH +: WIDTH];
        return DEFAULT_VAL;
    endfunction

    // Records this cycle's handshakes in the reference queue, then advances one clock.
    task automatic tick();
        logic acc;
        logic pp;
        acc     = bus.in_valid && bus.in_ready;
        pp      = bus.out_valid && bus.out_ready;
        did_pop = 1'b0;
        if (reset) begin
            q.delete();
`ifdef OPMUX_SELERR_EN
            err_exp = 1'b0;
`endif
        end else begin
            if (pp) begin
                did_pop = 1'b1;
                pop_act = bus.out_data;
                if (q.size() > 0) pop_exp = q.pop_front();
                else              pop_exp = 'x;
            end
            if (acc) q.push_back(ref_sel(bus.src, bus.sel));
`ifdef OPMUX_SELERR_EN
            if (acc && int'(bus.sel) >= NUM_SRC) err_exp = 1'b1;
            else if (err_clr)                    err_exp = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        bus.sel      = '0;
        bus.src      = {$urandom, $urandom, $urandom};
        tick();
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else passed++;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else passed++;
        checks++;
        if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data);
        else passed++;
`ifdef OPMUX_SELERR_EN
        checks++;
        if (sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b want 0", sel_err);
        else passed++;
`endif
    endtask

    task automatic test_select();
        logic [WIDTH-1:0] want[3];
        want = '{32'hA, 32'hB, 32'hC};
        bus.src       = {32'hC, 32'hB, 32'hA};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.sel = SEL_W'(i);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want[i])
                $display("FAIL select_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, bus.out_valid, bus.out_data, want[i]);
            else passed++;
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL select_drain: got valid=%b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_out_of_range();
        bus.src       = {$urandom, $urandom, $urandom};
        bus.sel       = 2'd3;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0)
            $display("FAIL oob_data: got valid=%b data=%h want valid=1 data=0",
                     bus.out_valid, bus.out_data);
        else passed++;
        tick();
`ifdef OPMUX_SELERR_EN
        tick();
        checks++;
        if (sel_err !== 1'b1) $display("FAIL oob_sticky: got %b want 1", sel_err);
        else passed++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (sel_err !== 1'b0) $display("FAIL oob_clear: got %b want 0", sel_err);
        else passed++;
        // Clear coinciding with a new out-of-range accept: the set must win.
        err_clr      = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        err_clr      = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (sel_err !== 1'b1) $display("FAIL oob_set_wins: got %b want 1", sel_err);
        else passed++;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`endif
    endtask

    // Leaves the pipe FULL holding 0x11 (main) and 0x22 (skid).
    task automatic fill_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sel       = 2'd0;
        bus.src       = {$urandom, $urandom, 32'h11};
        tick();
        bus.src       = {$urandom, $urandom, 32'h22};
        tick();
    endtask

    task automatic test_stall_skid();
        fill_full();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h11 || bus.out_valid !== 1'b1)
            $display("FAIL skid_full: got ready=%b valid=%b data=%h want ready=0 valid=1 data=11",
                     bus.in_ready, bus.out_valid, bus.out_data);
        else passed++;
        // Garbage requests while FULL must be ignored.
        for (int i = 0; i < 3; i++) begin
            bus.src = {$urandom, $urandom, $urandom};
            bus.sel = SEL_W'($urandom_range(0, 3));
            tick();
        end
        checks++;
        if (bus.out_data !== 32'h11 || bus.in_ready !== 1'b0)
            $display("FAIL skid_hold: got data=%h ready=%b want data=11 ready=0",
                     bus.out_data, bus.in_ready);
        else passed++;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (pop_act !== 32'h11 || bus.out_data !== 32'h22 || bus.in_ready !== 1'b1)
            $display("FAIL skid_pop1: got popped=%h next=%h ready=%b want 11 22 1",
                     pop_act, bus.out_data, bus.in_ready);
        else passed++;
        tick();
        checks++;
        if (pop_act !== 32'h22 || bus.out_valid !== 1'b0)
            $display("FAIL skid_pop2: got popped=%h valid=%b want 22 0", pop_act, bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset_full();
        int seen_bad;
        fill_full();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL rstfull_state: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
        else passed++;
        bus.out_ready = 1'b1;
        seen_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 1'b0) seen_bad++;
            tick();
        end
        checks++;
        if (seen_bad !== 0) $display("FAIL rstfull_stale: got %0d valid cycles want 0", seen_bad);
        else passed++;
    endtask

    task automatic test_soak();
        int errs_ready = 0, errs_valid = 0, errs_head = 0, errs_pop = 0, errs_err = 0;
        int pops = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            bus.sel       = SEL_W'($urandom_range(0, 3));
            bus.src       = {$urandom, $urandom, $urandom};
`ifdef OPMUX_SELERR_EN
            err_clr = ($urandom_range(0, 9) == 0);
            if (sel_err !== err_exp) errs_err++;
`endif
            if (bus.in_ready !== (q.size() < 2)) errs_ready++;
            if (bus.out_valid !== (q.size() > 0)) errs_valid++;
            if (q.size() > 0 && bus.out_data !== q[0]) errs_head++;
            tick();
            if (did_pop) begin
                pops++;
                if (pop_act !== pop_exp) begin
                    errs_pop++;
                    if (errs_pop <= 5)
                        $display("FAIL soak_pop: got %h want %h (cycle %0d)", pop_act, pop_exp, c);
                end
            end
        end
        bus.in_valid  = 1'b0;
`ifdef OPMUX_SELERR_EN
        err_clr = 1'b0;
        checks++;
        if (errs_err !== 0) $display("FAIL soak_sel_err: got %0d mismatching cycles want 0", errs_err);
        else passed++;
`endif
        checks++;
        if (errs_ready !== 0) $display("FAIL soak_in_ready: got %0d mismatching cycles want 0", errs_ready);
        else passed++;
        checks++;
        if (errs_valid !== 0) $display("FAIL soak_out_valid: got %0d mismatching cycles want 0", errs_valid);
        else passed++;
        checks++;
        if (errs_head !== 0) $display("FAIL soak_head: got %0d mismatching cycles want 0", errs_head);
        else passed++;
        checks++;
        if (errs_pop !== 0) $display("FAIL soak_order: got %0d bad pops want 0", errs_pop);
        else passed++;
        checks++;
        if (pops < 1000) $display("FAIL soak_activity: got %0d pops want >= 1000", pops);
        else passed++;
    endtask

    initial begin
`ifdef OPMUX_SELERR_EN
        err_clr = 1'b0;
        err_exp = 1'b0;
`endif
        test_reset();
        test_select();
        test_out_of_range();
        test_stall_skid();
        test_reset_full();
        test_soak();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
